// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, common command bytes and frame size.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_START,
    ST_SHIFT,
    ST_STOP,
    ST_ACK,
    ST_RELEASE
  } ps2_tx_state_e;

  localparam logic [7:0] PS2_CMD_LEDS   = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET  = 8'hFF;
  localparam logic [7:0] PS2_CMD_ENABLE = 8'hF4;

  localparam int unsigned PS2_FRAME_BITS = 11;

  function automatic logic ps2_odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_sync.sv
// Two-flop synchronizer for one PS/2 line plus a ce-gated falling-edge detector.
module ps2_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic ce_i,
  input  logic pin_i,
  output logic level_o,
  output logic fe_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Idle PS/2 lines float high, so reset to 1 to avoid a false edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= pin_i;
      sync_q <= meta_q;
      if (ce_i) prev_q <= sync_q;
    end
  end

  assign level_o = sync_q;
  assign fe_o    = ce_i & prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter (request-to-send, 11-bit frame, ack check).
// Define PS2TX_TIMEOUT_EN to add a frame watchdog of TIMEOUT ce ticks from clock release.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT = 880,
  parameter int unsigned TIMEOUT = 132000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ce,
  input  logic       ps2Ck,
  input  logic       ps2D,
  output logic       ps2CkOe,
  output logic       ps2DOe,
  input  logic [7:0] txData,
  input  logic       txReq,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int unsigned SHIFT_BITS = PS2_FRAME_BITS - 2;
  localparam logic [17:0] INH_LAST   = 18'(INHIBIT - 1);
  localparam logic [3:0]  SHIFT_LAST = 4'(SHIFT_BITS - 1);

  ps2_tx_state_e state_q, state_d;
  logic [8:0]    shift_q, shift_d;
  logic [3:0]    bitcnt_q, bitcnt_d;
  logic [17:0]   inh_q, inh_d;
  logic          ckoe_q, ckoe_d;
  logic          doe_q, doe_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          pend_q, pend_d;

  logic ck_lvl, ck_fe;
  logic d_lvl, d_fe_unused;

  ps2_sync u_sync_ck (
    .clk_i   (clock),
    .rst_i   (reset),
    .ce_i    (ce),
    .pin_i   (ps2Ck),
    .level_o (ck_lvl),
    .fe_o    (ck_fe)
  );

  ps2_sync u_sync_d (
    .clk_i   (clock),
    .rst_i   (reset),
    .ce_i    (ce),
    .pin_i   (ps2D),
    .level_o (d_lvl),
    .fe_o    (d_fe_unused)
  );

`ifdef PS2TX_TIMEOUT_EN
  localparam logic [17:0] TMO_LAST = 18'(TIMEOUT - 1);
  logic [17:0] tmo_q, tmo_d;

  always_ff @(posedge clock) begin
    if (reset) tmo_q <= '0;
    else       tmo_q <= tmo_d;
  end
`else
  logic [17:0] tmo_unused;
  assign tmo_unused = 18'(TIMEOUT);
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      shift_q  <= '0;
      bitcnt_q <= '0;
      inh_q    <= '0;
      ckoe_q   <= 1'b0;
      doe_q    <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      pend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      bitcnt_q <= bitcnt_d;
      inh_q    <= inh_d;
      ckoe_q   <= ckoe_d;
      doe_q    <= doe_d;
      done_q   <= done_d;
      err_q    <= err_d;
      pend_q   <= pend_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    bitcnt_d = bitcnt_q;
    inh_d    = inh_q;
    ckoe_d   = ckoe_q;
    doe_d    = doe_q;
    done_d   = 1'b0;
    err_d    = err_q;
    pend_d   = pend_q;
`ifdef PS2TX_TIMEOUT_EN
    tmo_d    = tmo_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (txReq) begin
          shift_d = {ps2_odd_parity(txData), txData};
          err_d   = 1'b0;
          pend_d  = 1'b0;
          inh_d   = '0;
          ckoe_d  = 1'b1;
          state_d = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        if (ce) begin
          if (inh_q == INH_LAST) begin
            doe_d   = 1'b1;
            state_d = ST_START;
          end else if (inh_q != '1) begin
            inh_d = inh_q + 18'd1;
          end
        end
      end
      ST_START: begin
        if (ce) begin
          ckoe_d   = 1'b0;
          bitcnt_d = '0;
          state_d  = ST_SHIFT;
`ifdef PS2TX_TIMEOUT_EN
          tmo_d    = '0;
`endif
        end
      end
      ST_SHIFT: begin
        if (ck_fe) begin
          doe_d    = ~shift_q[0];
          shift_d  = {1'b0, shift_q[8:1]};
          bitcnt_d = bitcnt_q + 4'd1;
          if (bitcnt_q == SHIFT_LAST) state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (ck_fe) begin
          doe_d   = 1'b0;
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        if (ck_fe) begin
          if (d_lvl) err_d  = 1'b1;
          else       pend_d = 1'b1;
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (ck_lvl && d_lvl) begin
          done_d  = pend_q;
          pend_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

`ifdef PS2TX_TIMEOUT_EN
    // Watchdog overrides whatever the protocol step decided this cycle.
    if (ce && (state_q == ST_SHIFT || state_q == ST_STOP ||
               state_q == ST_ACK   || state_q == ST_RELEASE)) begin
      if (tmo_q == TMO_LAST) begin
        err_d   = 1'b1;
        ckoe_d  = 1'b0;
        doe_d   = 1'b0;
        pend_d  = 1'b0;
        done_d  = 1'b0;
        state_d = ST_IDLE;
      end else if (tmo_q != '1) begin
        tmo_d = tmo_q + 18'd1;
      end
    end
`endif
  end

  assign ps2CkOe = ckoe_q;
  assign ps2DOe  = doe_q;
  assign busy    = (state_q != ST_IDLE);
  assign done    = done_q;
  assign error   = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboard bench for ps2_host_tx with an open-collector PS/2 device model.
module tb_ps2_host_tx;

  localparam int unsigned INH = 20;
  localparam int unsigned TMO = 3000;
  localparam int unsigned H   = 20;

  logic       clock;
  logic       reset;
  logic       ce;
  logic       dev_ck_low;
  logic       dev_d_low;
  logic       ps2Ck, ps2D;
  logic       ps2CkOe, ps2DOe;
  logic [7:0] txData;
  logic       txReq;
  logic       busy, done, error;

  assign ps2Ck = ~(ps2CkOe | dev_ck_low);
  assign ps2D  = ~(ps2DOe | dev_d_low);

  ps2_host_tx #(.INHIBIT(INH), .TIMEOUT(TMO)) dut (
    .clock   (clock),
    .reset   (reset),
    .ce      (ce),
    .ps2Ck   (ps2Ck),
    .ps2D    (ps2D),
    .ps2CkOe (ps2CkOe),
    .ps2DOe  (ps2DOe),
    .txData  (txData),
    .txReq   (txReq),
    .busy    (busy),
    .done    (done),
    .error   (error)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    ce = 1'b0;
    forever begin
      @(posedge clock);
      #1 ce = ~ce;
    end
  end

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  int exp_done = 0;
  logic [10:0] exp_frames[$];
  int          exp_out[$];   // 1 = done, 0 = error, 2 = abandoned by reset
  logic [10:0] got_frame;
  event        frame_ev;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Frame monitor: compares each captured device-side frame against the queue.
  initial begin : mon_frame
    logic [10:0] e;
    forever begin
      @(frame_ev);
      if (exp_frames.size() == 0) begin
        check("unexpected frame", 32'(got_frame), 32'h0);
      end else begin
        e = exp_frames.pop_front();
        check("frame bits", 32'(got_frame), 32'(e));
      end
    end
  end

  // Outcome monitor: at every busy fall, done/error must match the queued outcome.
  initial begin : mon_out
    logic bp;
    int   o;
    bp = 1'b0;
    forever begin
      @(negedge clock);
      if (done) done_cnt++;
      if (bp && !busy) begin
        if (exp_out.size() == 0) begin
          check("unexpected busy fall", 32'd1, 32'd0);
        end else begin
          o = exp_out.pop_front();
          check("done at busy fall", 32'(done), 32'(o == 1));
          check("error at busy fall", 32'(error), 32'(o == 0));
        end
      end
      bp = busy;
    end
  end

  // mode: 0 normal, 1 collide with a 0x55 request mid-frame, 2 reset during bit 4, 3 silent device
  task automatic send(input logic [7:0] d, input logic par, input int mode, input logic ack);
    logic [10:0] f;
    int n, guard;
    if (mode < 2) exp_frames.push_back({1'b1, par, d, 1'b0});
    if (mode == 2) exp_out.push_back(2);
`ifdef PS2TX_TIMEOUT_EN
    else if (mode == 3) exp_out.push_back(0);
`else
    else if (mode == 3) exp_out.push_back(2);
`endif
    else begin
      exp_out.push_back(ack ? 1 : 0);
      if (ack) exp_done++;
    end

    wait_clk(1);
    txData = d;
    txReq  = 1'b1;
    wait_clk(1);
    txReq  = 1'b0;
    txData = 8'h00;
    @(negedge clock);
    check("busy after accept", 32'(busy), 32'd1);
    check("clock pulled after accept", 32'(ps2CkOe), 32'd1);
    check("error cleared on accept", 32'(error), 32'd0);

    n = 0;
    guard = 0;
    while (ps2CkOe && guard < 10000) begin
      if (ce) n++;
      guard++;
      @(negedge clock);
    end
    check("inhibit+start ticks", 32'(n), 32'(INH + 1));
    check("start bit driven at release", 32'(ps2DOe), 32'd1);

    if (mode == 3) begin
`ifdef PS2TX_TIMEOUT_EN
      n = 0;
      guard = 0;
      while (busy && guard < int'(8 * TMO)) begin
        if (ce) n++;
        guard++;
        @(negedge clock);
      end
      check("timeout ticks", 32'(n), 32'(TMO));
      check("clock released after timeout", 32'(ps2CkOe), 32'd0);
      check("data released after timeout", 32'(ps2DOe), 32'd0);
      check("error after timeout", 32'(error), 32'd1);
`else
      repeat (4 * TMO) @(negedge clock);
      check("still busy without watchdog", 32'(busy), 32'd1);
      wait_clk(1);
      reset = 1'b1;
      wait_clk(1);
      reset = 1'b0;
`endif
      wait_clk(4);
      return;
    end

    wait_clk(H);
    f[0] = ps2D;
    for (int k = 1; k <= 10; k++) begin
      dev_ck_low = 1'b1;
      wait_clk(H);
      dev_ck_low = 1'b0;
      wait_clk(H);
      f[k] = ps2D;
      if (mode == 1 && k == 3) begin
        txData = 8'h55;
        txReq  = 1'b1;
        wait_clk(1);
        txReq  = 1'b0;
        txData = 8'h00;
      end
      if (mode == 2 && k == 5) begin
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("ckOe after reset", 32'(ps2CkOe), 32'd0);
        check("dOe after reset", 32'(ps2DOe), 32'd0);
        check("busy after reset", 32'(busy), 32'd0);
        check("done after reset", 32'(done), 32'd0);
        wait_clk(1);
        reset = 1'b0;
        wait_clk(4);
        return;
      end
    end
    dev_d_low  = ack;
    dev_ck_low = 1'b1;
    wait_clk(H);
    dev_ck_low = 1'b0;
    wait_clk(H);
    dev_d_low  = 1'b0;
    got_frame  = f;
    -> frame_ev;

    guard = 0;
    while (busy && guard < 1000) begin
      guard++;
      @(negedge clock);
    end
    check("busy falls after frame", 32'(busy), 32'd0);
    wait_clk(4);
    if (mode == 1) begin
      wait_clk(2 * INH);
      check("no queued request", 32'(busy | ps2CkOe), 32'd0);
    end
  endtask

  initial begin
    reset      = 1'b1;
    dev_ck_low = 1'b0;
    dev_d_low  = 1'b0;
    txData     = 8'h00;
    txReq      = 1'b0;
    wait_clk(3);
    @(negedge clock);
    check("reset ckOe", 32'(ps2CkOe), 32'd0);
    check("reset dOe", 32'(ps2DOe), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset error", 32'(error), 32'd0);
    wait_clk(1);
    reset = 1'b0;
    wait_clk(4);

    send(8'hED, 1'b1, 0, 1'b1);
    send(8'h01, 1'b0, 0, 1'b1);
    send(8'hFF, 1'b1, 0, 1'b1);
    send(8'h00, 1'b1, 0, 1'b1);
    send(8'hED, 1'b1, 0, 1'b0);
    send(8'hFF, 1'b1, 0, 1'b1);
    send(8'hF4, 1'b0, 1, 1'b1);
    send(8'hED, 1'b1, 2, 1'b1);
    send(8'hFF, 1'b1, 0, 1'b1);
    send(8'h00, 1'b1, 3, 1'b1);

    wait_clk(10);
    check("done pulse count", 32'(done_cnt), 32'(exp_done));
    check("frames left", 32'(exp_frames.size()), 32'd0);
    check("outcomes left", 32'(exp_out.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter. It sends single command bytes to the keyboard, for example 0xED (set LEDs) and 0xFF (reset), over the same two open-collector lines that the keyboard receiver samples. It performs the full host request-to-send sequence: clock inhibit, start bit, eight data bits, odd parity, stop bit and device acknowledge. It sits beside `keyboard` in `glue`, clocked from `clock` with the `pe8M8` enable, and drives the PS/2 pins through open-drain output enables.

## Interface
Parameters:
- `INHIBIT`, default 880: `ce` ticks ps2Ck is held low before the start bit (100 µs at 8.8 MHz).
- `TIMEOUT`, default 132000: `ce` ticks allowed for a whole frame, measured from clock release (15 ms). Used only with `PS2TX_TIMEOUT_EN`.

Ports:
- `clock` in 1: system clock; all logic on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `ce` in 1: clock enable (8.8 MHz pulse); all protocol timing counts `ce` ticks.
- `ps2Ck` in 1: raw PS/2 clock pin level.
- `ps2D` in 1: raw PS/2 data pin level.
- `ps2CkOe` out 1: 1 = pull PS/2 clock low; 0 = release.
- `ps2DOe` out 1: 1 = pull PS/2 data low; 0 = release.
- `txData` in 8: byte to send; latched when a request is accepted.
- `txReq` in 1: one-`clock` request pulse.
- `busy` out 1: frame in progress; the receiver ignores the lines while it is high.
- `done` out 1: one-`clock` pulse when the frame completes with ack.
- `error` out 1: sticky; set on NACK or timeout, cleared on the next accepted request.

## Operation
- Pin conditioning: ps2Ck and ps2D pass through a two-flop synchronizer on `clock`. A falling edge (`fe`) is detected on `ce` ticks only (previous sample 1, current sample 0).
- Request acceptance: `txReq` is accepted only in IDLE. A request while `busy` is ignored, with no queueing. On acceptance:
  - `txData` is latched into the shift register.
  - Parity is computed as `~^txData`.
  - `error` is cleared.
- States:
  - IDLE: both OEs 0, `busy` 0. An accepted request goes to INHIBIT.
  - INHIBIT: ps2CkOe=1. Count INHIBIT `ce` ticks, then go to START.
  - START: ps2CkOe=1, ps2DOe=1 for exactly one `ce` tick. Then set ps2CkOe=0, clear the bit counter and go to SHIFT.
  - SHIFT: on each `fe`, ps2DOe = ~(next bit). Bits go out LSB-first for data bits 0–7, then parity. Leave after the 9th `fe`.
  - STOP: on the 10th `fe`, ps2DOe=0 (stop bit = 1).
  - ACK: on the 11th `fe`, sample ps2D.
    - 0: ack; go to RELEASE with `done` pending.
    - 1: NACK; set `error` and go to RELEASE.
  - RELEASE: wait until synchronized ps2Ck=1 and ps2D=1. Then go to IDLE, pulsing `done` if it is pending.
- Arithmetic: the bit counter is 4 bits. The inhibit and timeout counters are 18 bits, saturating.
- Reset mid-frame: the next `clock` edge forces IDLE, both OEs 0, and `busy`/`done`/`error` 0. Abandoning the frame is acceptable; the device times it out itself.

## Timing
- Reset values: ps2CkOe=0, ps2DOe=0, busy=0, done=0, error=0.
- `busy` rises on the `clock` after the accepted `txReq`. It falls on the same edge that `done` pulses, or that RELEASE exits after an error.
- First clock pull occurs 1 `clock` after acceptance. Clock release occurs INHIBIT+1 `ce` ticks later.
- Data changes exactly one `ce` tick after the detected device falling edge (synchronizer latency 2 clocks plus edge detect). This is well inside the device's half-period of ≥30 µs.
- A new request can be accepted on the `clock` after `busy` falls.

## Configuration
- `PS2TX_TIMEOUT_EN` defined:
  - A counter runs from clock release.
  - Reaching TIMEOUT in SHIFT, STOP or ACK sets `error`, releases both lines and goes to IDLE. `done` is not pulsed.
  - A stuck line in RELEASE also times out to IDLE.
- Undefined: no watchdog. A silent device leaves the block in SHIFT until `reset`.

## Structure
- Shared package `ps2_pkg`:
  - state enum (IDLE, INHIBIT, START, SHIFT, STOP, ACK, RELEASE)
  - command constants `PS2_CMD_LEDS`=8'hED, `PS2_CMD_RESET`=8'hFF, `PS2_CMD_ENABLE`=8'hF4
  - frame bit count 11
- Sub-module `ps2_sync`: two-flop synchronizer plus `ce`-gated falling-edge detect for one line. It is instantiated twice here and is reusable by `keyboard`.

## Test plan
- Send 0xED with a device model that clocks at 12.5 kHz and acks → data line bits after start are 1,0,1,1,0,1,1,1, parity 1, stop 1; `done` pulses once; `error`=0.
- Send 0x01 → parity bit 0. Send 0xFF → parity 1. Send 0x00 → parity 1.
- Device leaves data high at the 11th falling edge → `error`=1, no `done`, `busy` drops after both lines are high.
- Assert `txReq` with 0x55 while `busy` during a 0xF4 frame → only 0xF4 is transmitted.
- Assert `reset` during bit 4 → both OEs 0 and `busy`=0 on the next edge; a following 0xFF frame completes normally.
- With `PS2TX_TIMEOUT_EN`, the device never clocks → `error` is set after 132000 `ce` ticks and the lines are released. Without the macro, the block is still `busy` at 200000 ticks.
